// File: rtl/id_ex_if.sv
// ID/EX stage boundary: decode-side inputs, write-back bypass, stage controls, EX-side outputs.
// Pure wiring, no latency of its own.
// flush/ex_stall come from downstream; hazard_stall goes back upstream.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8
);
    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [15:0]       id_imm16;
    logic              id_zext;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              ex_stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              hazard_stall;
    logic [15:0]       bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs_data, id_rt_data, id_imm16, id_zext,
               id_rs, id_rt, id_rd, id_ctrl, wb_we, wb_addr, wb_data, flush, ex_stall,
        input  ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_ctrl, hazard_stall, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs_data, id_rt_data, id_imm16, id_zext,
               id_rs, id_rt, id_rd, id_ctrl, wb_we, wb_addr, wb_data, flush, ex_stall,
        output ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
               ex_ctrl, hazard_stall, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with immediate extension, write-back bypass and load-use bubble insertion.
// Latency: one cycle from decode inputs to EX outputs; hazard_stall is combinational.
// ex_stall holds EX contents; a load-use hazard holds upstream and injects one bubble.
module id_ex_pipe_reg #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int CTRL_W      = 8,
    parameter int MEMREAD_BIT = 4
) (
    input  logic    clk,
    input  logic    rst,
    id_ex_if.slave  bus
);
    localparam int EXT_W = DATA_W - 16;

    logic              ex_valid_q;
    logic [DATA_W-1:0] ex_pc_q;
    logic [DATA_W-1:0] ex_rs_data_q;
    logic [DATA_W-1:0] ex_rt_data_q;
    logic [DATA_W-1:0] ex_imm_q;
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rt_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [15:0]       bubble_cnt_q;

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic              load_use;
    logic              ex_clr;
    logic              ex_hold;

    always_comb begin
        imm_ext = bus.id_zext ? {{EXT_W{1'b0}}, bus.id_imm16}
                              : {{EXT_W{bus.id_imm16[15]}}, bus.id_imm16};
        // Register-file write happens in the same cycle as the read, so bypass it; r0 is never written.
        rs_fwd = (bus.wb_we && (bus.wb_addr != '0) && (bus.wb_addr == bus.id_rs)) ? bus.wb_data
                                                                                   : bus.id_rs_data;
        rt_fwd = (bus.wb_we && (bus.wb_addr != '0) && (bus.wb_addr == bus.id_rt)) ? bus.wb_data
                                                                                   : bus.id_rt_data;
        load_use = ex_valid_q && ex_ctrl_q[MEMREAD_BIT] && (ex_rt_q != '0) && bus.id_valid &&
                   ((ex_rt_q == bus.id_rs) || (ex_rt_q == bus.id_rt));
        ex_clr  = rst || bus.flush || (!bus.ex_stall && load_use);
        ex_hold = bus.ex_stall;
    end

    always_ff @(posedge clk) begin
        if (ex_clr) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_ctrl_q    <= '0;
        end else if (!ex_hold) begin
            ex_valid_q   <= bus.id_valid;
            ex_pc_q      <= bus.id_pc;
            ex_rs_data_q <= rs_fwd;
            ex_rt_data_q <= rt_fwd;
            ex_imm_q     <= imm_ext;
            ex_rs_q      <= bus.id_rs;
            ex_rt_q      <= bus.id_rt;
            ex_rd_q      <= bus.id_rd;
            ex_ctrl_q    <= bus.id_valid ? bus.id_ctrl : '0;
        end
    end

    // Only a bubble actually inserted counts; a hazard masked by flush or ex_stall does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (!bus.flush && !bus.ex_stall && load_use && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_pc        = ex_pc_q;
    assign bus.ex_rs_data   = ex_rs_data_q;
    assign bus.ex_rt_data   = ex_rt_data_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.hazard_stall = load_use;
    assign bus.bubble_cnt   = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vectors push expected EX state into a queue,
// a monitor pops one entry after every clock edge and compares.
module tb_id_ex_pipe_reg;
    logic clk = 1'b0;
    logic rst;

    id_ex_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(8)) bus ();

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CTRL_W(8), .MEMREAD_BIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        v;
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctrl;
        logic        hz;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;
    int   vec_id = 0;

    function automatic exp_t mk(logic v, logic [31:0] pc, logic [31:0] rsd, logic [31:0] rtd,
                                logic [31:0] imm, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [7:0] ctrl, logic hz, logic [15:0] cnt);
        exp_t e;
        e.id = 0; e.v = v; e.pc = pc; e.rsd = rsd; e.rtd = rtd; e.imm = imm;
        e.rs = rs; e.rt = rt; e.rd = rd; e.ctrl = ctrl; e.hz = hz; e.cnt = cnt;
        return e;
    endfunction

    function automatic exp_t zero_st(logic [15:0] cnt);
        return mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 8'h00, 1'b0, cnt);
    endfunction

    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [15:0] imm16, input logic zext,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [7:0] ctrl);
        bus.id_valid = v; bus.id_pc = pc; bus.id_rs_data = rsd; bus.id_rt_data = rtd;
        bus.id_imm16 = imm16; bus.id_zext = zext;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.id_ctrl = ctrl;
    endtask

    task automatic step(input exp_t e);
        exp_t t;
        t = e;
        t.id = vec_id;
        vec_id++;
        q.push_back(t);
        @(negedge clk);
    endtask

    task automatic lw_in();
        drv(1'b1, 32'h700, 32'h11, 32'h22, 16'h0000, 1'b0, 5'd1, 5'd5, 5'd0, 8'h10);
    endtask

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL v%0d %s: got %h want %h", id, nm, act, exp);
        end
    endtask

    // Monitor: EX state and hazard_stall are sampled just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.id, "ex_valid",     {31'b0, bus.ex_valid},     {31'b0, e.v});
                chk(e.id, "ex_pc",        bus.ex_pc,                 e.pc);
                chk(e.id, "ex_rs_data",   bus.ex_rs_data,            e.rsd);
                chk(e.id, "ex_rt_data",   bus.ex_rt_data,            e.rtd);
                chk(e.id, "ex_imm",       bus.ex_imm,                e.imm);
                chk(e.id, "ex_rs",        {27'b0, bus.ex_rs},        {27'b0, e.rs});
                chk(e.id, "ex_rt",        {27'b0, bus.ex_rt},        {27'b0, e.rt});
                chk(e.id, "ex_rd",        {27'b0, bus.ex_rd},        {27'b0, e.rd});
                chk(e.id, "ex_ctrl",      {24'b0, bus.ex_ctrl},      {24'b0, e.ctrl});
                chk(e.id, "hazard_stall", {31'b0, bus.hazard_stall}, {31'b0, e.hz});
                chk(e.id, "bubble_cnt",   {16'b0, bus.bubble_cnt},   {16'b0, e.cnt});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'h0;
        bus.flush = 1'b0; bus.ex_stall = 1'b0;
        drv(1'b1, 32'h900, 32'h99, 32'h98, 16'h1234, 1'b0, 5'd4, 5'd5, 5'd6, 8'h10);
        step(zero_st(16'd0));
        step(zero_st(16'd0));

        // Immediate extension
        rst = 1'b0;
        drv(1'b1, 32'h100, 32'h11, 32'h22, 16'hFFF0, 1'b0, 5'd1, 5'd2, 5'd3, 8'h03);
        step(mk(1, 32'h100, 32'h11, 32'h22, 32'hFFFFFFF0, 1, 2, 3, 8'h03, 0, 0));
        drv(1'b1, 32'h104, 32'h11, 32'h22, 16'hFFF0, 1'b1, 5'd1, 5'd2, 5'd3, 8'h03);
        step(mk(1, 32'h104, 32'h11, 32'h22, 32'h0000FFF0, 1, 2, 3, 8'h03, 0, 0));

        // Write-back bypass
        bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hAA;
        drv(1'b1, 32'h108, 32'h11, 32'h22, 16'h0005, 1'b0, 5'd3, 5'd2, 5'd4, 8'h03);
        step(mk(1, 32'h108, 32'hAA, 32'h22, 32'h5, 3, 2, 4, 8'h03, 0, 0));
        bus.wb_addr = 5'd0;
        drv(1'b1, 32'h10C, 32'h11, 32'h22, 16'h8000, 1'b0, 5'd0, 5'd0, 5'd4, 8'h03);
        step(mk(1, 32'h10C, 32'h11, 32'h22, 32'hFFFF8000, 0, 0, 4, 8'h03, 0, 0));
        bus.wb_addr = 5'd7; bus.wb_data = 32'h55;
        drv(1'b1, 32'h110, 32'h11, 32'h22, 16'h7FFF, 1'b0, 5'd1, 5'd7, 5'd4, 8'h03);
        step(mk(1, 32'h110, 32'h11, 32'h55, 32'h00007FFF, 1, 7, 4, 8'h03, 0, 0));
        bus.wb_we = 1'b0;
        drv(1'b1, 32'h114, 32'h11, 32'h22, 16'h7FFF, 1'b0, 5'd7, 5'd7, 5'd4, 8'h03);
        step(mk(1, 32'h114, 32'h11, 32'h22, 32'h00007FFF, 7, 7, 4, 8'h03, 0, 0));

        // Load-use: lw then a consumer of its rt
        drv(1'b1, 32'h200, 32'h11, 32'h22, 16'h0000, 1'b0, 5'd1, 5'd5, 5'd0, 8'h10);
        step(mk(1, 32'h200, 32'h11, 32'h22, 32'h0, 1, 5, 0, 8'h10, 1, 0));
        drv(1'b1, 32'h204, 32'h33, 32'h44, 16'h0008, 1'b0, 5'd5, 5'd6, 5'd7, 8'h03);
        step(zero_st(16'd1));
        step(mk(1, 32'h204, 32'h33, 32'h44, 32'h8, 5, 6, 7, 8'h03, 0, 1));

        // Priority: ex_stall over hazard, then flush over both
        drv(1'b1, 32'h300, 32'h11, 32'h22, 16'h0000, 1'b0, 5'd1, 5'd5, 5'd0, 8'h10);
        step(mk(1, 32'h300, 32'h11, 32'h22, 32'h0, 1, 5, 0, 8'h10, 1, 1));
        bus.ex_stall = 1'b1;
        drv(1'b1, 32'h304, 32'h33, 32'h44, 16'h0008, 1'b0, 5'd5, 5'd6, 5'd7, 8'h03);
        step(mk(1, 32'h300, 32'h11, 32'h22, 32'h0, 1, 5, 0, 8'h10, 1, 1));
        bus.flush = 1'b1;
        step(zero_st(16'd1));
        bus.flush = 1'b0; bus.ex_stall = 1'b0;
        step(mk(1, 32'h304, 32'h33, 32'h44, 32'h8, 5, 6, 7, 8'h03, 0, 1));

        // Invalid decode slot: ctrl forced to zero, no hazard raised
        drv(1'b0, 32'h400, 32'h11, 32'h22, 16'h0000, 1'b0, 5'd1, 5'd5, 5'd2, 8'hFF);
        step(mk(0, 32'h400, 32'h11, 32'h22, 32'h0, 1, 5, 2, 8'h00, 0, 1));
        drv(1'b1, 32'h500, 32'h11, 32'h22, 16'h0000, 1'b0, 5'd1, 5'd5, 5'd0, 8'h10);
        step(mk(1, 32'h500, 32'h11, 32'h22, 32'h0, 1, 5, 0, 8'h10, 1, 1));
        drv(1'b0, 32'h504, 32'h33, 32'h44, 16'h0000, 1'b0, 5'd5, 5'd5, 5'd1, 8'h03);
        step(mk(0, 32'h504, 32'h33, 32'h44, 32'h0, 5, 5, 1, 8'h00, 0, 1));

        // Reset during ex_stall with valid contents, then normal capture
        drv(1'b1, 32'h600, 32'h11, 32'h22, 16'h0000, 1'b0, 5'd1, 5'd5, 5'd0, 8'h10);
        step(mk(1, 32'h600, 32'h11, 32'h22, 32'h0, 1, 5, 0, 8'h10, 1, 1));
        rst = 1'b1; bus.ex_stall = 1'b1;
        step(zero_st(16'd0));
        rst = 1'b0; bus.ex_stall = 1'b0;
        drv(1'b1, 32'h604, 32'h33, 32'h44, 16'h0010, 1'b0, 5'd1, 5'd2, 5'd3, 8'h03);
        step(mk(1, 32'h604, 32'h33, 32'h44, 32'h10, 1, 2, 3, 8'h03, 0, 0));

        // Repeated bubbles: a self-dependent lw alternates load / bubble
        lw_in();
        for (int k = 0; k < 10; k++) begin
            step(mk(1, 32'h700, 32'h11, 32'h22, 32'h0, 1, 5, 0, 8'h10, 1, 16'(k)));
            step(zero_st(16'(k + 1)));
        end
        step(mk(1, 32'h700, 32'h11, 32'h22, 32'h0, 1, 5, 0, 8'h10, 1, 16'd10));

        // Saturation: preload the counter just below the limit while stalled
        bus.ex_stall = 1'b1;
        force dut.bubble_cnt_q = 16'hFFFE;
        step(mk(1, 32'h700, 32'h11, 32'h22, 32'h0, 1, 5, 0, 8'h10, 1, 16'hFFFE));
        release dut.bubble_cnt_q;
        bus.ex_stall = 1'b0;
        step(zero_st(16'hFFFF));
        step(mk(1, 32'h700, 32'h11, 32'h22, 32'h0, 1, 5, 0, 8'h10, 1, 16'hFFFF));
        step(zero_st(16'hFFFF));
        step(mk(1, 32'h700, 32'h11, 32'h22, 32'h0, 1, 5, 0, 8'h10, 1, 16'hFFFF));

        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending entries want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of PC, operands and immediate.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 Parameter CTRL_W, default 8, width of the control bundle carried to later stages.
REQ-004 Parameter MEMREAD_BIT, default 4, index in the control bundle of the memRead flag.
REQ-005 The module SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 id_valid  in  1  decode slot holds a real instruction.
REQ-009 id_pc  in  DATA_W  PC of the decode instruction.
REQ-010 id_rs_data, id_rt_data  in  DATA_W each  register-file read data.
REQ-011 id_imm16  in  16  raw immediate field.
REQ-012 id_zext  in  1  1 = zero-extend immediate, 0 = sign-extend.
REQ-013 id_rs, id_rt, id_rd  in  REG_AW each  register specifiers.
REQ-014 id_ctrl  in  CTRL_W  decoded control bundle.
REQ-015 wb_we, wb_addr, wb_data  in  1 / REG_AW / DATA_W  write-back port of the same cycle.
REQ-016 flush  in  1  kill the instruction entering EX.
REQ-017 ex_stall  in  1  downstream stall; hold EX contents.
REQ-018 ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  1 / DATA_W ×4  registered EX-stage contents.
REQ-019 ex_rs, ex_rt, ex_rd, ex_ctrl  out  REG_AW ×3 / CTRL_W  registered specifiers and control.
REQ-020 hazard_stall  out  1  combinational load-use stall request to PC and IF/ID.
REQ-021 bubble_cnt  out  16  count of inserted load-use bubbles.

Function
REQ-022 Immediate SHALL be sign- or zero-extended from 16 to DATA_W per id_zext before registering.
REQ-023 Write-back bypass: if wb_we=1, wb_addr≠0 and wb_addr==id_rs, captured rs data SHALL be wb_data, else id_rs_data; same rule independently for rt.
REQ-024 hazard_stall SHALL be 1 iff ex_valid=1, ex_ctrl[MEMREAD_BIT]=1, ex_rt≠0, id_valid=1 and (ex_rt==id_rs or ex_rt==id_rt); otherwise 0.
REQ-025 Per rising edge, priority rst > flush > ex_stall > hazard_stall > load.
REQ-026 flush: ex_valid←0, ex_ctrl←0; other outputs don't-care but SHALL be cleared to 0.
REQ-027 ex_stall (no flush): all EX registers hold; bubble_cnt holds.
REQ-028 hazard_stall (no flush/ex_stall): bubble inserted — ex_valid←0, ex_ctrl←0, data/specifiers←0; bubble_cnt increments.
REQ-029 Load: all EX registers take decode values, ex_valid←id_valid; if id_valid=0, ex_ctrl SHALL be 0.
REQ-030 Latency: one cycle from decode inputs to EX outputs.
REQ-031 bubble_cnt SHALL saturate at 16'hFFFF, never wrap.
REQ-032 A hazard asserted during ex_stall SHALL NOT insert a bubble or count; evaluated again next cycle.
REQ-033 After one bubble, hazard_stall SHALL deassert because ex_valid=0.

Reset
REQ-034 With rst=1 at an edge, all outputs registers and bubble_cnt SHALL become 0, overriding flush and stalls.
REQ-035 Reset mid-stall SHALL discard held contents; first post-reset edge loads normally.

Verification
REQ-036 Load: id_valid=1, id_pc=0x100, imm16=0xFFF0, zext=0 -> next cycle ex_pc=0x100, ex_imm=0xFFFFFFF0, ex_valid=1; zext=1 -> ex_imm=0x0000FFF0.
REQ-037 Bypass: wb_we=1, wb_addr=id_rs=3, wb_data=0xAA, id_rs_data=0x11 -> ex_rs_data=0xAA; wb_addr=0 -> 0x11.
REQ-038 Load-use: EX holds lw (memRead=1, ex_rt=5), id_rs=5 -> hazard_stall=1, next cycle ex_valid=0, ex_ctrl=0, bubble_cnt=1, hazard_stall=0.
REQ-039 Priority: flush=1, ex_stall=1, hazard active together -> ex_valid=0, bubble_cnt unchanged; ex_stall alone with hazard -> EX holds, count unchanged.
REQ-040 Saturation: force 65536 bubbles -> bubble_cnt stays 0xFFFF.
REQ-041 Reset: rst=1 during ex_stall with valid contents -> all outputs 0 next cycle; rst=0 then load -> normal capture.
